// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbitration logic.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int                 DIGIT_W        = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE_DEF = 4'hF;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, with wrap.
// Zero latency; no flow control, o_vld low when no request is set.
module rr_priority_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_vld
);

    int w_dist;
    int w_best;

    // Distance 0 is the slot right after the pointer; the old owner sits at N-1.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_best = N;
        w_dist = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + 2 * N - int'(i_ptr) - 1) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = PTR_W'(j);
                o_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the two-digit display with min/max hold and a blank gap between owners.
// Grant one cycle after request, digits one cycle after grant; requesters simply wait while not granted.
module display_arbiter
    import display_pkg::*;
#(
    parameter int                 NUM_REQ    = 3,
    parameter int                 MIN_HOLD   = 50_000_000,
    parameter int                 MAX_HOLD   = 200_000_000,
    parameter int                 GAP_CYCLES = 5_000_000,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [DIGIT_W*NUM_REQ-1:0] d1_in,
    input  logic [DIGIT_W*NUM_REQ-1:0] d2_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DIGIT_W-1:0]         disp_1,
    output logic [DIGIT_W-1:0]         disp_2,
    output logic                       busy
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (MAX_HOLD > GAP_CYCLES) ? MAX_HOLD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [DIGIT_W-1:0]   r_d1, w_d1_nxt;
    logic [DIGIT_W-1:0]   r_d2, w_d2_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_pick_vld;
    logic [DIGIT_W-1:0]   w_own_d1;
    logic [DIGIT_W-1:0]   w_own_d2;
    logic                 w_own_req;
    logic                 w_other_req;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // The one-hot grant selects the owner's digits, avoiding a variable part-select.
    always_comb begin
        w_own_d1 = '0;
        w_own_d2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_d1 = w_own_d1 | d1_in[i*DIGIT_W +: DIGIT_W];
                w_own_d2 = w_own_d2 | d2_in[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign w_own_req   = |(req & r_grant);
    assign w_other_req = |(req & ~r_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_d1_nxt    = r_d1;
        w_d2_nxt    = r_d2;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_d1_nxt   = BLANK_CODE;
                w_d2_nxt   = BLANK_CODE;
                w_busy_nxt = 1'b0;
                if (w_pick_vld) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = w_pick_gnt;
                    w_ptr_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_OWN: begin
                w_d1_nxt = w_own_d1;
                w_d2_nxt = w_own_d2;
                if (r_cnt < MAX_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if ((r_cnt >= MIN_LAST) &&
                    (!w_own_req || ((r_cnt >= MAX_LAST) && w_other_req))) begin
                    w_state_nxt = ST_GAP;
                    w_grant_nxt = '0;
                    w_d1_nxt    = BLANK_CODE;
                    w_d2_nxt    = BLANK_CODE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GAP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt >= GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_d1    <= BLANK_CODE;
            r_d2    <= BLANK_CODE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= PTR_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_d1    <= w_d1_nxt;
            r_d2    <= w_d2_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant  = r_grant;
    assign disp_1 = r_d1;
    assign disp_2 = r_d2;
    assign busy   = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: reference model of ownership/gap timing plus directed scenarios.
module tb_display_arbiter;

    localparam int N    = 3;
    localparam int MINH = 4;
    localparam int MAXH = 8;
    localparam int GAPC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] d1_in;
    logic [11:0] d2_in;
    logic [2:0]  grant;
    logic [3:0]  disp_1;
    logic [3:0]  disp_2;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    int          m_owner;
    int          m_held;
    int          m_gap;
    int          m_last;
    logic [3:0]  m_d1;
    logic [3:0]  m_d2;

    int          g[34];
    int          g_exp[34];

    display_arbiter #(
        .NUM_REQ    (N),
        .MIN_HOLD   (MINH),
        .MAX_HOLD   (MAXH),
        .GAP_CYCLES (GAPC),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .d1_in  (d1_in),
        .d2_in  (d2_in),
        .grant  (grant),
        .disp_1 (disp_1),
        .disp_2 (disp_2),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an owner holds for a counted number of cycles, then a gap countdown.
    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = N - 1;
        m_d1    = 4'hF;
        m_d2    = 4'hF;
    endtask

    task automatic model_step();
        logic [11:0] sh;
        logic [2:0]  others;
        int          c;
        if (m_owner >= 0) begin
            others = req & ~3'(1 << m_owner);
            if (m_held >= MINH &&
                (((req >> m_owner) & 3'b001) == 3'b000 || (m_held >= MAXH && others != 3'b000))) begin
                m_owner = -1;
                m_gap   = GAPC;
                m_d1    = 4'hF;
                m_d2    = 4'hF;
            end else begin
                sh     = d1_in >> (4 * m_owner);
                m_d1   = sh[3:0];
                sh     = d2_in >> (4 * m_owner);
                m_d2   = sh[3:0];
                m_held = m_held + 1;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && ((req >> c) & 3'b001) != 3'b000) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("cmp_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
                chk("cmp_disp_1", disp_1, m_d1);
                chk("cmp_disp_2", disp_2, m_d2);
                chk("cmp_busy", busy, (m_owner >= 0 || m_gap > 0) ? 1 : 0);
            end
        end
    end

    task automatic async_rst_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_disp_1"}, disp_1, 4'hF);
        chk({tag, "_disp_2"}, disp_2, 4'hF);
        chk({tag, "_busy"}, busy, 0);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((grant != 3'b000 || busy) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", (grant == 3'b000 && !busy) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int idx;
        int rv[7];
        int rl[7];
        rv = '{1, 0, 2, 0, 4, 0, 1};
        rl = '{8, 3, 8, 3, 8, 3, 1};

        rst   = 1'b1;
        req   = 3'b000;
        d1_in = {4'h5, 4'h3, 4'h1};
        d2_in = {4'h9, 4'h7, 4'h2};
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Idle with no requests.
        repeat (20) @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_disp_1", disp_1, 4'hF);
        chk("idle_busy", busy, 0);
        async_rst_check("idle_rst");

        // Single requester 1, held 10 cycles then dropped.
        @(negedge clk); req = 3'b010;
        @(negedge clk);
        chk("s2_grant", grant, 3'b010);
        chk("s2_disp_early", disp_1, 4'hF);
        @(negedge clk);
        chk("s2_disp_1", disp_1, 4'h3);
        chk("s2_disp_2", disp_2, 4'h7);
        chk("s2_busy", busy, 1);
        repeat (8) @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        chk("s2_drop_grant", grant, 0);
        chk("s2_drop_disp", disp_1, 4'hF);
        chk("s2_gap1_busy", busy, 1);
        @(negedge clk);
        chk("s2_gap2_busy", busy, 1);
        @(negedge clk);
        chk("s2_idle_busy", busy, 0);

        // One-cycle pulse still earns the minimum hold.
        @(negedge clk); req = 3'b001;
        @(negedge clk); req = 3'b000;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (grant == 3'b001) n++;
            @(negedge clk);
        end
        chk("s3_hold_len", n, MINH);

        // All three requesting: rotation with max hold and gap+idle separation.
        async_rst_check("s4_rst");
        @(negedge clk); req = 3'b111;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            g[i] = grant;
        end
        idx = 0;
        for (int r = 0; r < 7; r++) begin
            for (int j = 0; j < rl[r]; j++) begin
                g_exp[idx] = rv[r];
                idx++;
            end
        end
        for (int i = 0; i < 34; i++) chk("s4_rotate", g[i], g_exp[i]);
        req = 3'b000;
        wait_idle(40);

        // Owner 2 alone keeps the grant; a late contender preempts at once.
        @(negedge clk); req = 3'b100;
        repeat (30) @(negedge clk);
        chk("s5_held", grant, 3'b100);
        req = 3'b101;
        @(negedge clk);
        chk("s5_release", grant, 0);
        repeat (3) @(negedge clk);
        chk("s5_next", grant, 3'b001);
        req = 3'b000;
        wait_idle(40);

        // Reset mid-ownership; pointer returns so requester 0 wins next.
        @(negedge clk); req = 3'b010;
        repeat (4) @(negedge clk);
        chk("s6_pre_grant", grant, 3'b010);
        chk("s6_pre_disp", disp_1, 4'h3);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_grant", grant, 0);
        chk("s6_rst_disp_1", disp_1, 4'hF);
        chk("s6_rst_disp_2", disp_2, 4'hF);
        chk("s6_rst_busy", busy, 0);
        req = 3'b011;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_first", grant, 3'b001);
        req = 3'b000;
        wait_idle(40);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
